// File: rtl/jt9346_master.sv
// Microwire master for 93C46/93C06-style serial EEPROMs.
// Serialises one command per start pulse, reads back data and polls ready/busy.
module jt9346_master #(
  parameter int DW   = 16,
  parameter int DIV  = 4,
  parameter int TOUT = 4096,
  localparam int AW  = (DW == 16) ? 6 : 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sclk,
  output logic          sdi,
  output logic          scs,
  input  logic          sdo
);

  localparam int FW  = 3 + AW + DW;
  localparam int BW  = $clog2(FW + 1);
  localparam int DCW = $clog2(DIV);
  localparam int PCW = $clog2(DIV + TOUT + 1);

  typedef enum logic [2:0] {
    OP_READ, OP_WRITE, OP_ERASE, OP_EWEN, OP_EWDS, OP_ERAL, OP_WRAL, OP_RSV
  } op_e;

  typedef enum logic [2:0] {
    IDLE, SEL, SHIFT, RDATA, DESEL, POLL, DESEL2
  } state_e;

  state_e          state;
  op_e             op_q;
  logic [FW-2:0]   frame;
  logic [BW-1:0]   bit_cnt;
  logic [DCW-1:0]  div_cnt;
  logic [PCW-1:0]  poll_cnt;
  logic [DW-2:0]   rsh;

  logic [AW+1:0]   cmd_d;
  logic [FW-2:0]   frame_d;
  logic [BW-1:0]   len_d;
  logic            has_data;
  logic            div_last;
  logic            is_poll;

  // Frame excludes the start bit, which is driven directly on entry to SEL.
  always_comb begin
    cmd_d    = '0;
    has_data = 1'b0;
    case (op_e'(op))
      OP_READ:  cmd_d = {2'b10, addr};
      OP_WRITE: begin cmd_d = {2'b01, addr}; has_data = 1'b1; end
      OP_ERASE: cmd_d = {2'b11, addr};
      OP_EWEN:  cmd_d = {4'b0011, {(AW-2){1'b0}}};
      OP_EWDS:  cmd_d = '0;
      OP_ERAL:  cmd_d = {4'b0010, {(AW-2){1'b0}}};
      OP_WRAL:  begin cmd_d = {4'b0001, {(AW-2){1'b0}}}; has_data = 1'b1; end
      default:  cmd_d = '0;
    endcase
    frame_d = {cmd_d, {DW{has_data}} & wdata};
    len_d   = has_data ? BW'(FW) : BW'(3 + AW);
  end

  assign div_last = (div_cnt == DCW'(DIV - 1));
  assign is_poll  = op_q inside {OP_WRITE, OP_ERASE, OP_ERAL, OP_WRAL};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_READ;
      frame    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      poll_cnt <= '0;
      rsh      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sclk     <= 1'b0;
      sdi      <= 1'b0;
      scs      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          err     <= 1'b0;
          op_q    <= op_e'(op);
          frame   <= frame_d;
          bit_cnt <= len_d;
          div_cnt <= '0;
          if (op_e'(op) == OP_RSV) begin
            state <= DESEL;
          end else begin
            state <= SEL;
            scs   <= 1'b1;
            sdi   <= 1'b1;
          end
        end
        SEL: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state <= SHIFT;
            sclk  <= 1'b1;
          end
        end
        SHIFT, RDATA: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            if (sclk) begin
              // Falling transition: advance sdi, and in RDATA capture sdo.
              sclk  <= 1'b0;
              sdi   <= frame[FW-2];
              frame <= {frame[FW-3:0], 1'b0};
              if (state == RDATA) begin
                rsh <= {rsh[DW-3:0], sdo};
                if (bit_cnt == BW'(1)) rdata <= {rsh, sdo};
              end
            end else if (bit_cnt != BW'(1)) begin
              bit_cnt <= bit_cnt - 1'b1;
              sclk    <= 1'b1;
            end else if (state == SHIFT && op_q == OP_READ) begin
              state   <= RDATA;
              bit_cnt <= BW'(DW);
              sclk    <= 1'b1;
            end else begin
              state <= DESEL;
              scs   <= 1'b0;
              sdi   <= 1'b0;
            end
          end
        end
        DESEL: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            if (is_poll) begin
              state    <= POLL;
              scs      <= 1'b1;
              poll_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        POLL: begin
          if (poll_cnt < PCW'(DIV)) begin
            poll_cnt <= poll_cnt + 1'b1;
          end else if (sdo) begin
            state <= DESEL2;
            scs   <= 1'b0;
          end else if (poll_cnt == PCW'(DIV + TOUT - 1)) begin
            state <= DESEL2;
            scs   <= 1'b0;
            err   <= 1'b1;
          end else if (poll_cnt != '1) begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        DESEL2: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt9346_master.sv
// Bench for jt9346_master: drives commands against a behavioural 93C46 (x16)
// slave and checks frame shape, read data, poll behaviour and timeout.
module tb_jt9346_master;
  localparam int DW = 16, AW = 6, DIV = 4, TOUT = 4096;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          busy, done, err, sclk, sdi, scs, sdo;

  always #5 clk = ~clk;

  jt9346_master #(.DW(DW), .DIV(DIV), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err),
    .sclk(sclk), .sdi(sdi), .scs(scs), .sdo(sdo)
  );

  int passed = 0, total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Bus monitor: sclk pulses inside scs, scs-high window lengths, done pulses, protocol violations.
  logic m_scs_q = 1'b0, m_sclk_q = 1'b0, m_sdi_q = 1'b0;
  int pulses = 0, dones = 0, wins = 0, win_len = 0, win_last = 0, win_prev = 0, viol = 0;
  always @(negedge clk) begin
    if (scs === 1'b1 && sclk === 1'b1 && !m_sclk_q) pulses++;
    if (done === 1'b1) dones++;
    if (scs === 1'b1) win_len++;
    else if (m_scs_q) begin
      win_prev = win_last; win_last = win_len; win_len = 0; wins++;
    end
    if (scs === 1'b0 && !m_scs_q && sclk !== m_sclk_q) viol++;
    if (scs === 1'b1 && m_scs_q && sdi !== m_sdi_q && !(m_sclk_q && sclk === 1'b0)) viol++;
    m_scs_q  = (scs === 1'b1);
    m_sclk_q = (sclk === 1'b1);
    m_sdi_q  = (sdi === 1'b1);
  end

  // Behavioural 93C46 x16 slave, evaluated on settled bus values.
  logic [DW-1:0] mem [64];
  logic          s_filled = 1'b0, s_we = 1'b0, s_scs_q = 1'b0, s_sclk_q = 1'b0;
  logic          sdo_m = 1'b0, stuck0 = 1'b0;
  int            s_st = 0, s_n = 0, s_busy = 0;
  logic [7:0]    s_cmd = '0;
  logic [DW-1:0] s_din = '0, s_rd = '0;

  always @(negedge clk) begin
    if (!s_filled) begin
      for (int i = 0; i < 64; i++) mem[i] = '1;
      s_filled = 1'b1;
    end
    if (s_busy > 0) s_busy--;
    if (scs !== 1'b1) begin
      if (s_scs_q && s_st == 4) begin
        case (s_cmd[7:6])
          2'b01: if (s_we) begin mem[s_cmd[5:0]] = s_din; s_busy = 2; end
          2'b11: if (s_we) begin mem[s_cmd[5:0]] = '1; s_busy = 2; end
          2'b00: case (s_cmd[5:4])
            2'b11: s_we = 1'b1;
            2'b00: s_we = 1'b0;
            2'b10: if (s_we) begin for (int i = 0; i < 64; i++) mem[i] = '1; s_busy = 64; end
            default: if (s_we) begin for (int i = 0; i < 64; i++) mem[i] = s_din; s_busy = 64; end
          endcase
          default: ;
        endcase
      end
      s_st = 0; sdo_m = 1'b0;
    end else begin
      if (sclk === 1'b1 && !s_sclk_q) begin
        case (s_st)
          0: if (sdi === 1'b1) begin s_st = 1; s_n = 0; end
          1: begin
            s_cmd = {s_cmd[6:0], sdi}; s_n++;
            if (s_n == 8) begin
              s_n = 0;
              if (s_cmd[7:6] == 2'b10) begin s_st = 3; s_rd = mem[s_cmd[5:0]]; sdo_m = 1'b0; end
              else if (s_cmd[7:6] == 2'b01 || s_cmd[7:4] == 4'b0001) s_st = 2;
              else s_st = 4;
            end
          end
          2: begin s_din = {s_din[DW-2:0], sdi}; s_n++; if (s_n == DW) s_st = 4; end
          3: begin sdo_m = s_rd[DW-1]; s_rd = {s_rd[DW-2:0], 1'b0}; end
          default: ;
        endcase
      end
      if (s_st == 0) sdo_m = (s_busy == 0);
    end
    s_scs_q  = (scs === 1'b1);
    s_sclk_q = (sclk === 1'b1);
  end

  assign sdo = sdo_m & ~stuck0;

  task automatic run_cmd(input logic [2:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int p, output int w, output int dn, output int wl, output int wp,
                         output logic eb);
    int p0, w0, d0, cyc;
    @(negedge clk);
    p0 = pulses; w0 = wins; d0 = dones;
    op = o; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    eb = err;
    check($sformatf("busy_after_start op%0d", o), busy, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < TOUT + 2000) begin @(negedge clk); cyc++; end
    if (done !== 1'b1) begin
      total++;
      $display("FAIL cmd_timeout op%0d: no done after %0d clks", o, cyc);
    end
    repeat (3) @(negedge clk);
    p = pulses - p0; w = wins - w0; dn = dones - d0; wl = win_last; wp = win_prev;
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    int            exp_pulses;
    int            exp_wins;
    int            poll_lo;
    int            poll_hi;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int p, w, dn, wl, wp, fl, cyc, p0, w0, d0;
    logic eb;

    vecs[0]  = '{3'd0, 6'd0,  16'h0000, 16'hFFFF, 25, 1, 0, 0};
    vecs[1]  = '{3'd3, 6'd0,  16'h0000, 16'h0000,  9, 1, 0, 0};
    vecs[2]  = '{3'd1, 6'd5,  16'hA55A, 16'h0000, 25, 2, DIV + 1, DIV + 2};
    vecs[3]  = '{3'd0, 6'd5,  16'h0000, 16'hA55A, 25, 1, 0, 0};
    vecs[4]  = '{3'd6, 6'd0,  16'h1234, 16'h0000, 25, 2, 40, 80};
    vecs[5]  = '{3'd0, 6'd63, 16'h0000, 16'h1234, 25, 1, 0, 0};
    vecs[6]  = '{3'd4, 6'd0,  16'h0000, 16'h0000,  9, 1, 0, 0};
    vecs[7]  = '{3'd1, 6'd3,  16'h0BAD, 16'h0000, 25, 2, DIV + 1, DIV + 2};
    vecs[8]  = '{3'd0, 6'd3,  16'h0000, 16'h1234, 25, 1, 0, 0};
    vecs[9]  = '{3'd3, 6'd0,  16'h0000, 16'h0000,  9, 1, 0, 0};
    vecs[10] = '{3'd2, 6'd63, 16'h0000, 16'h0000,  9, 2, DIV + 1, DIV + 2};
    vecs[11] = '{3'd0, 6'd63, 16'h0000, 16'hFFFF, 25, 1, 0, 0};
    vecs[12] = '{3'd0, 6'd5,  16'h0000, 16'h1234, 25, 1, 0, 0};
    vecs[13] = '{3'd5, 6'd0,  16'h0000, 16'h0000,  9, 2, 40, 80};
    vecs[14] = '{3'd0, 6'd7,  16'h0000, 16'hFFFF, 25, 1, 0, 0};
    vecs[15] = '{3'd7, 6'd0,  16'h0000, 16'h0000,  0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; op = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_scs", scs, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, p, w, dn, wl, wp, eb);
      check($sformatf("v%0d_pulses", i), p, vecs[i].exp_pulses);
      check($sformatf("v%0d_windows", i), w, vecs[i].exp_wins);
      check($sformatf("v%0d_done_count", i), dn, 1);
      check($sformatf("v%0d_err", i), err, 1'b0);
      if (vecs[i].exp_wins > 0) begin
        fl = (vecs[i].exp_wins == 2) ? wp : wl;
        check($sformatf("v%0d_frame_len", i), fl, DIV * (1 + 2 * vecs[i].exp_pulses));
      end
      if (vecs[i].exp_wins == 2)
        check_range($sformatf("v%0d_poll_len", i), wl, vecs[i].poll_lo, vecs[i].poll_hi);
      if (vecs[i].op == 3'd0)
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
    end

    // Ready never asserted: timeout after DIV settle clks plus TOUT samples.
    stuck0 = 1'b1;
    run_cmd(3'd1, 6'd9, 16'h0F0F, p, w, dn, wl, wp, eb);
    check("tout_err", err, 1'b1);
    check("tout_done_count", dn, 1);
    check("tout_poll_len", wl, DIV + TOUT);
    check("tout_scs", scs, 1'b0);
    stuck0 = 1'b0;
    run_cmd(3'd0, 6'd9, 16'h0000, p, w, dn, wl, wp, eb);
    check("tout_err_cleared", eb, 1'b0);
    check("tout_read_back", rdata, 16'h0F0F);

    // Start while busy with a different op must be ignored.
    @(negedge clk);
    p0 = pulses; w0 = wins; d0 = dones;
    op = 3'd0; addr = 6'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    op = 3'd6; wdata = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("ign_done_seen", done, 1'b1);
    repeat (3) @(negedge clk);
    check("ign_done_count", dones - d0, 1);
    check("ign_windows", wins - w0, 1);
    check("ign_pulses", pulses - p0, 25);
    check("ign_rdata", rdata, 16'hFFFF);

    // Reset in the middle of a WRITE frame aborts it.
    @(negedge clk);
    op = 3'd1; addr = 6'd2; wdata = 16'hDEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scs", scs, 1'b0);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata", rdata, 16'h0000);
    rst = 1'b0;
    run_cmd(3'd0, 6'd2, 16'h0000, p, w, dn, wl, wp, eb);
    check("midrst_read_pulses", p, 25);
    check("midrst_read_rdata", rdata, 16'hFFFF);

    check("bus_violations", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jt9346_master.md
Name: jt9346_master

Overview:
- Host-side Microwire master that drives a 93C46/93C06-compatible serial EEPROM (sclk/sdi/scs/sdo) from a parallel command interface.
- Sits directly upstream of the EEPROM model/chip: game CPU glue or NVRAM loader issues commands; this block serialises them, reads back data and polls ready/busy.
- One instruction per start pulse; scs is dropped between instructions.

Parameters:
- DW, 16, data word width (16 or 8); AW derived = 6 when DW==16, else 7.
- DIV, 4, clk cycles per sclk half-period (min 2).
- TOUT, 4096, max clk cycles spent polling ready before declaring error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  command strobe, sampled only when busy=0
- op  in  3  0=READ 1=WRITE 2=ERASE 3=EWEN 4=EWDS 5=ERAL 6=WRAL 7=reserved(no-op, done pulse)
- addr  in  AW  word address (READ/WRITE/ERASE)
- wdata  in  DW  write data (WRITE/WRAL)
- rdata  out  DW  last read word
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  set if ready poll timed out; cleared on next accepted start
- sclk  out  1  serial clock to EEPROM
- sdi  out  1  serial data to EEPROM
- scs  out  1  chip select, active high
- sdo  in  1  EEPROM data out / ready(1) busy(0)

Behaviour:
- Reset (sync, rst=1 at clk edge): sclk=0 sdi=0 scs=0 busy=0 done=0 err=0 rdata=0, state IDLE. Reset mid-command aborts immediately; scs low resets the slave.
- Accept: IDLE and start=1 -> latch op/addr/wdata, busy=1 next cycle, err=0. start while busy ignored.
- Frame bits MSB first: start bit 1, 2 opcode bits, AW address bits. Opcodes: READ 10+addr, WRITE 01+addr, ERASE 11+addr; EWEN/EWDS/ERAL/WRAL use 00 with address top two bits 11/00/10/01, rest 0. WRITE/WRAL append DW data bits. Frame length 3+AW (+DW).
- States: IDLE -> SEL -> SHIFT -> (RDATA) -> DESEL -> (POLL -> DESEL2) -> IDLE.
- SEL: scs=1, sclk=0, sdi=first bit, hold DIV clks.
- SHIFT: each bit = DIV clks sclk high then DIV clks sclk low; sdi updates only on sclk falling transition (and at SEL), stable across rising edge.
- RDATA (READ only): slave emits dummy 0 on last address rising edge; master issues DW more sclk pulses with sdi=0, samples sdo on the clk where sclk falls, shifts into rdata MSB first. rdata updated as a whole when the last bit is sampled.
- DESEL: sclk=0, scs=0 for DIV clks (tCSL).
- POLL (WRITE, ERASE, ERAL, WRAL only): scs=1, sclk=0; after DIV settle clks sample sdo each clk; sdo=1 -> DESEL2 (scs=0 DIV clks) -> IDLE. Counter reaching TOUT -> err=1, DESEL2, IDLE.
- READ/EWEN/EWDS/reserved skip POLL.
- done=1 for exactly one clk on the IDLE-return cycle, busy=0 that same cycle; new start accepted that cycle.
- sclk never toggles while scs=0. Counters: bit counter width ceil log2(3+AW+DW+1); poll counter saturating.

Test Plan:
- After slave reset fill: READ addr 0 -> scs/sclk frame of 9+16 pulses, rdata=16'hFFFF, done pulse, err=0.
- EWEN, WRITE addr 5 wdata 16'hA55A, READ 5 -> rdata=16'hA55A; WRITE poll sees sdo=1 within DIV+2 clks.
- WRAL wdata 16'h1234 -> poll waits ~64 clks busy; then READ 63 -> 16'h1234; ERASE 63, READ 63 -> 16'hFFFF.
- sdo tied 0 during WRITE -> err=1 after TOUT poll clks, done pulse, scs=0; next start clears err.
- start pulsed mid-command with different op -> ignored; exactly one done per accepted command.
- rst asserted mid-SHIFT -> next clk scs=0 sclk=0 busy=0; following READ returns correct data.
